// File: rtl/fp_operand_gen.sv
// fp_operand_gen: stimulus stage producing legal IEEE-754 single-precision
// operand pairs (A, B) from two 32-bit Galois LFSRs, one pair per
// valid/ready transfer, NUM_SAMPLES pairs per run.
// Optional build macro: FPGEN_EXP_CLAMP_EN. When defined, each operand
// exponent is forced into 112..143 so quotients cannot overflow or
// underflow, and no candidate is ever rejected.
module fp_operand_gen #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_SAMPLES = 20000,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'h1234_5678
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [15:0]     sample_idx,
  output logic            busy,
  output logic            done,
  output logic [15:0]     reject_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_HOLD, S_DONE} state_e;

  localparam logic [XLEN-1:0] LFSR_MASK  = 32'h8020_0003;
  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [XLEN-1:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [XLEN-1:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
  localparam logic [15:0]     LAST_IDX   = 16'(NUM_SAMPLES - 1);

  function automatic logic [XLEN-1:0] lfsr_next(input logic [XLEN-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // Maps a raw LFSR word onto the operand actually presented.
  function automatic logic [XLEN-1:0] shape(input logic [XLEN-1:0] s);
`ifdef FPGEN_EXP_CLAMP_EN
    return {s[31], 8'd112 + {3'b000, s[27:23]}, s[22:0]};
`else
    return s;
`endif
  endfunction

  // Zero/denormal (exp 00) and Inf/NaN (exp FF) are not legal operands.
  function automatic logic is_legal(input logic [XLEN-1:0] x);
    return (x[30:23] != 8'h00) && (x[30:23] != 8'hFF);
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            valid_q, valid_d;
  logic [15:0]     idx_q, idx_d;
  logic [15:0]     rej_q, rej_d;

  logic [XLEN-1:0] step_a, step_b, cand_a, cand_b;
  logic            pair_ok, last_pair;

  assign step_a    = lfsr_next(lfsr_a_q);
  assign step_b    = lfsr_next(lfsr_b_q);
  assign cand_a    = shape(step_a);
  assign cand_b    = shape(step_b);
  assign pair_ok   = is_legal(cand_a) && is_legal(cand_b);
  assign last_pair = (idx_q == LAST_IDX);

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_a_q <= SEED_A_EFF;
      lfsr_b_q <= SEED_B_EFF;
      a_q      <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      rej_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      rej_q    <= rej_d;
    end
  end

  // Next-state logic: start is honoured only from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_GEN;
      S_GEN:          if (pair_ok) state_d = S_HOLD;
      S_HOLD:         if (out_ready) state_d = last_pair ? S_DONE : S_GEN;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values: LFSRs step only in GEN, pair held in HOLD.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path can infer a latch.
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    rej_d    = rej_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_a_d = SEED_A_EFF;
          lfsr_b_d = SEED_B_EFF;
          idx_d    = '0;
          rej_d    = '0;
        end
      end
      S_GEN: begin
        lfsr_a_d = step_a;
        lfsr_b_d = step_b;
        if (pair_ok) begin
          a_d     = cand_a;
          b_d     = cand_b;
          valid_d = 1'b1;
        end else if (rej_q != 16'hFFFF) begin
          rej_d = rej_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (!last_pair) idx_d = idx_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: status decoded from state, data straight from registers.
  always_comb begin
    busy       = (state_q == S_GEN) || (state_q == S_HOLD);
    done       = (state_q == S_DONE);
    out_valid  = valid_q;
    A          = a_q;
    B          = b_q;
    sample_idx = idx_q;
    reject_cnt = rej_q;
  end

endmodule

// File: doc/fp_operand_gen.md
Name: fp_operand_gen

Overview:
- Upstream stimulus stage for the approximate floating-point divider and its error-calculation block.
- Generates NUM_SAMPLES pseudo-random, legal IEEE-754 single-precision operand pairs (A, B) from two LFSRs.
- Presents each pair on a valid/ready handshake, so the divider/error pipeline can consume one pair per accepted transfer.
- Rejects zero/denormal/Inf/NaN candidates in hardware, so error statistics are never polluted by special values.

Parameters:
- XLEN, 32, operand width; only 32 supported.
- NUM_SAMPLES, 20000, pairs emitted per run; range 1..65535.
- SEED_A, 32'h0000_0001, LFSR A load value; a value of 0 is replaced by 32'h0000_0001.
- SEED_B, 32'h1234_5678, LFSR B load value; a value of 0 is replaced by 32'h0000_0001.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE, ignored otherwise.
- out_ready  input  1  consumer accepts the current pair.
- out_valid  output  1  A/B hold a legal pair.
- A  output  XLEN  dividend.
- B  output  XLEN  divisor.
- sample_idx  output  16  index of the pair currently presented (0-based).
- busy  output  1  high in GEN or HOLD.
- done  output  1  high in DONE.
- reject_cnt  output  16  rejected candidate cycles this run; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: out_valid=0, A=0, B=0, sample_idx=0, busy=0, done=0, reject_cnt=0, state=IDLE, LFSRs loaded with their seeds.
- Reset mid-run gives the same result, and any pending pair is dropped.
- LFSR:
  - 32-bit Galois, right-shift form, mask 32'h8020_0003.
  - Next state = lsb ? (s>>1)^mask : (s>>1).
  - Both LFSRs step once per GEN cycle and never step in other states.
- Candidate legality: exponent field [30:23] is neither 8'h00 nor 8'hFF, checked for both candidates.
- States and transitions:
  - IDLE: on start, reload seeds, clear sample_idx/reject_cnt/done, go to GEN next cycle.
  - GEN:
    - Step both LFSRs.
    - If both new values are legal, register them into A/B, set out_valid=1 and go to HOLD. out_valid rises one cycle after the GEN cycle.
    - Otherwise increment reject_cnt (saturating) and stay in GEN.
  - HOLD:
    - A/B/sample_idx stay stable while out_valid=1 and out_ready=0.
    - On out_ready=1 the transfer completes and out_valid drops next cycle.
    - If sample_idx==NUM_SAMPLES-1, go to DONE; sample_idx keeps its last value.
    - Otherwise increment sample_idx and go to GEN.
  - DONE: done=1 and out_valid=0; start returns to IDLE behaviour (a fresh run with identical sequence).
- Throughput and latency:
  - Best case one pair per 2 cycles (GEN, HOLD with out_ready already high).
  - start-to-first-valid latency is 2 cycles, plus one per rejected candidate.
- Boundary cases:
  - start while busy: ignored.
  - start together with reset: reset wins.
  - out_ready high outside HOLD: no effect.
  - NUM_SAMPLES=1: single transfer, then DONE.
  - reject_cnt at 16'hFFFF stays 16'hFFFF.
- Sign and mantissa bits come straight from the LFSR; no other filtering.

Optional Feature:
- Macro FPGEN_EXP_CLAMP_EN.
- Defined: the exponent field of each operand is replaced by 8'd112 + {3'b000, s[27:23]}, giving range 112..143 (about 2^-15..2^16). The legality check then always passes and reject_cnt stays 0, keeping quotients clear of overflow/underflow.
- Undefined: full exponent range with special-value rejection as above.

Test Plan:
- Reject path: SEED_A=1, SEED_B=1; reset, start. First GEN step yields 32'h8020_0003 (exp 0), so it is rejected and reject_cnt=1. Second step yields 32'hC030_0002 (exp 8'h80) for both LFSRs, so out_valid rises with A=B=32'hC030_0002 and sample_idx=0.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → out_valid=1 and A/B/sample_idx unchanged. Raise out_ready for 1 cycle → exactly one transfer, sample_idx becomes 1 after the next accepted pair.
- Full run: NUM_SAMPLES=20, out_ready=1 → exactly 20 transfers, and every A/B exponent is not in {00, FF}. done=1 after the 20th transfer, busy=0, out_valid=0, and A/B match a bit-accurate software LFSR model.
- Reset mid-run: assert reset after 5 transfers → next cycle out_valid=0, sample_idx=0, state IDLE. Restart reproduces the identical first pair.
- Restart from DONE: start pulse → same 20-pair sequence as the first run, reject_cnt equal to the first run's final value.
- FPGEN_EXP_CLAMP_EN defined: 1000-sample run → every exponent in 112..143 and reject_cnt=0.
